// File: rtl/pll_reset_sequencer.sv
// Reset sequencer for the system PLL: pulses PLL reset, waits for and qualifies
// lock, holds the downstream reset, then watches for lock loss while running.
module pll_reset_sequencer #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 5000000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int SYS_RST_HOLD_CYC = 256,
    parameter int MAX_RETRIES      = 7
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic       lock_lost
);

    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_CD  = (LOCK_STABLE_CYC > SYS_RST_HOLD_CYC) ? LOCK_STABLE_CYC : SYS_RST_HOLD_CYC;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t       RST_LAST     = cnt_t'(RST_PULSE_CYC - 1);
    localparam cnt_t       TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT_CYC - 1);
    localparam cnt_t       STABLE_LAST  = cnt_t'(LOCK_STABLE_CYC - 1);
    localparam cnt_t       HOLD_LAST    = cnt_t'(SYS_RST_HOLD_CYC - 1);
    localparam logic [2:0] RETRY_MAX    = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_SYS_HOLD,
        S_RUN,
        S_FAIL
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] retry_q, retry_d, retry_inc;
    logic [1:0] sync_q, sync_d;
    logic       pll_rst_q, pll_rst_d;
    logic       sys_rst_q, sys_rst_d;
    logic       ready_q, ready_d;
    logic       fail_q, fail_d;
    logic       lock_lost_q, lock_lost_d;
    logic       locked_s;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= S_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            sync_q      <= sync_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    always_comb begin
        // pll_locked is asynchronous; only the second synchronizer stage is trusted
        sync_d      = {sync_q[0], pll_locked};
        locked_s    = sync_q[1];
        state_d     = state_q;
        cnt_d       = cnt_q + cnt_t'(1);
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        retry_inc   = (retry_q == RETRY_MAX) ? RETRY_MAX : retry_q + 3'd1;

        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                // lock seen on the timeout cycle still counts as success
                if (locked_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_inc;
                    cnt_d   = '0;
                    state_d = (retry_inc == RETRY_MAX) ? S_FAIL : S_PLL_RST;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_SYS_HOLD;
                    cnt_d   = '0;
                end
            end
            S_SYS_HOLD: begin
                if (!locked_s) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d     = S_PLL_RST;
                    lock_lost_d = 1'b1;
                end
            end
            S_FAIL: begin
                cnt_d = '0;
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // outputs are registered from the next state so they move with the transition
        pll_rst_d = (state_d == S_PLL_RST) || (state_d == S_FAIL);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed bring-up/fault scenarios plus random
// lock/reset activity, all compared every cycle against a phase/elapsed-time model.
module tb_pll_reset_sequencer;

    localparam int RST_PULSE  = 4;
    localparam int TIMEOUT    = 100;
    localparam int STABLE_CYC = 8;
    localparam int HOLD_CYC   = 4;
    localparam int MAXR       = 3;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [2:0] retry_cnt;
    logic       lock_lost;

    int total = 0;
    int bad   = 0;

    pll_reset_sequencer #(
        .RST_PULSE_CYC   (RST_PULSE),
        .LOCK_TIMEOUT_CYC(TIMEOUT),
        .LOCK_STABLE_CYC (STABLE_CYC),
        .SYS_RST_HOLD_CYC(HOLD_CYC),
        .MAX_RETRIES     (MAXR)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .lock_lost (lock_lost)
    );

    always #10 refclk = ~refclk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which phase we are in and how many edges have elapsed in it.
    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STB  = 2;
    localparam int PH_HOLD = 3;
    localparam int PH_RUN  = 4;
    localparam int PH_FAIL = 5;

    int ph = PH_RST;
    int el = 0;
    int m_retry = 0;
    bit m_lost = 0;
    bit mvalid = 0;
    bit seen1 = 0;
    bit seen2 = 0;

    task automatic enter(input int p);
        ph = p;
        el = 0;
    endtask

    task automatic model_step();
        bit ls;
        if (rst) begin
            enter(PH_RST);
            m_retry = 0;
            m_lost  = 0;
            seen1   = 0;
            seen2   = 0;
            mvalid  = 1;
        end else if (mvalid) begin
            ls     = seen2;
            seen2  = seen1;
            seen1  = pll_locked;
            m_lost = 0;
            case (ph)
                PH_RST: begin
                    el++;
                    if (el == RST_PULSE) enter(PH_WAIT);
                end
                PH_WAIT: begin
                    if (ls) enter(PH_STB);
                    else begin
                        el++;
                        if (el == TIMEOUT) begin
                            m_retry = (m_retry < MAXR) ? m_retry + 1 : MAXR;
                            enter((m_retry == MAXR) ? PH_FAIL : PH_RST);
                        end
                    end
                end
                PH_STB: begin
                    if (!ls) enter(PH_WAIT);
                    else begin
                        el++;
                        if (el == STABLE_CYC) enter(PH_HOLD);
                    end
                end
                PH_HOLD: begin
                    if (!ls) enter(PH_RST);
                    else begin
                        el++;
                        if (el == HOLD_CYC) begin
                            enter(PH_RUN);
                            m_retry = 0;
                        end
                    end
                end
                PH_RUN: begin
                    if (!ls) begin
                        m_lost = 1;
                        enter(PH_RST);
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge refclk);
        model_step();
    end

    initial forever begin
        @(negedge refclk);
        if (mvalid) begin
            chk("pll_rst",   pll_rst,   (ph == PH_RST || ph == PH_FAIL) ? 1 : 0);
            chk("sys_rst",   sys_rst,   (ph != PH_RUN) ? 1 : 0);
            chk("ready",     ready,     (ph == PH_RUN) ? 1 : 0);
            chk("fail",      fail,      (ph == PH_FAIL) ? 1 : 0);
            chk("retry_cnt", retry_cnt, m_retry);
            chk("lock_lost", lock_lost, m_lost);
        end
    end

    function automatic bit cond(input int which);
        case (which)
            0:       return ready;
            1:       return retry_cnt == 3'd1;
            2:       return fail;
            3:       return lock_lost;
            default: return !pll_rst;
        endcase
    endfunction

    // n = number of rising edges until the condition is first observed
    task automatic wait_cond(input string name, input int which, input int limit, output int n);
        n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (!cond(which) && n < limit);
        if (!cond(which)) begin
            total++;
            bad++;
            $display("FAIL %s: not seen within %0d cycles", name, n);
        end
    endtask

    task automatic restart(input logic lock_val);
        rst = 1'b1;
        repeat (2) @(negedge refclk);
        pll_locked = lock_val;
        rst = 1'b0;
    endtask

    initial begin
        int n, n2, k, len;
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        chk("reset_pll_rst", pll_rst, 1);
        chk("reset_sys_rst", sys_rst, 1);
        chk("reset_ready", ready, 0);
        chk("reset_fail", fail, 0);
        chk("reset_retry", retry_cnt, 0);
        chk("reset_lock_lost", lock_lost, 0);

        // clean bring-up
        pll_locked = 1'b1;
        rst = 1'b0;
        wait_cond("pll_rst_release", 4, 50, n);
        chk("pll_rst_low_cycle", n, 4);
        wait_cond("ready_clean", 0, 50, n2);
        chk("ready_clean_cycle", n + n2, 17);
        chk("model_ready_clean", (ph == PH_RUN) ? 1 : 0, 1);
        chk("retry_clean", retry_cnt, 0);

        // lock loss while running
        repeat (5) @(negedge refclk);
        pll_locked = 1'b0;
        wait_cond("lock_lost_pulse", 3, 20, n);
        chk("lock_lost_delay", n, 3);
        chk("lost_ready", ready, 0);
        chk("lost_sys_rst", sys_rst, 1);
        chk("lost_pll_rst", pll_rst, 1);
        @(negedge refclk);
        chk("lost_one_cycle", lock_lost, 0);
        pll_locked = 1'b1;
        wait_cond("ready_after_loss", 0, 200, n);

        // one-cycle lock glitch during STABLE
        restart(1'b1);
        repeat (7) @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        wait_cond("ready_glitch", 0, 100, n);
        chk("ready_glitch_cycle", n + 8, 23);
        chk("retry_glitch", retry_cnt, 0);

        // single timeout, then lock
        restart(1'b0);
        wait_cond("first_timeout", 1, 300, n);
        chk("timeout_cycle", n, 104);
        k = 0;
        while (pll_rst && k < 20) begin
            k++;
            @(negedge refclk);
        end
        chk("retry_pulse_len", k, 4);
        pll_locked = 1'b1;
        wait_cond("ready_after_retry", 0, 100, n);
        chk("retry_cleared", retry_cnt, 0);

        // never locks -> FAIL
        restart(1'b0);
        wait_cond("fail_entry", 2, 500, n);
        chk("fail_cycle", n, 3 * (RST_PULSE + TIMEOUT));
        chk("fail_retry", retry_cnt, 3);
        chk("fail_pll_rst", pll_rst, 1);
        chk("fail_sys_rst", sys_rst, 1);
        chk("model_fail", (ph == PH_FAIL) ? 1 : 0, 1);
        pll_locked = 1'b1;
        repeat (30) @(negedge refclk);
        chk("fail_sticky", fail, 1);
        rst = 1'b1;
        @(negedge refclk);
        chk("fail_cleared", fail, 0);
        chk("fail_rst_pll_rst", pll_rst, 1);
        chk("fail_rst_retry", retry_cnt, 0);
        rst = 1'b0;
        wait_cond("ready_after_fail", 0, 50, n);
        chk("ready_after_fail_cycle", n, 17);

        // reset pulse during SYS_HOLD
        restart(1'b1);
        repeat (14) @(negedge refclk);
        rst = 1'b1;
        @(negedge refclk);
        chk("hold_rst_ready", ready, 0);
        chk("hold_rst_sys_rst", sys_rst, 1);
        chk("hold_rst_pll_rst", pll_rst, 1);
        rst = 1'b0;
        wait_cond("ready_after_hold_rst", 0, 50, n);
        chk("ready_after_hold_rst_cycle", n, 17);

        // random lock activity with occasional resets
        for (int i = 0; i < 120; i++) begin
            pll_locked = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) len = $urandom_range(1, 3);
            else len = pll_locked ? $urandom_range(1, 60) : $urandom_range(1, 130);
            for (int j = 0; j < len; j++) begin
                rst = ($urandom_range(0, 299) == 0);
                @(negedge refclk);
            end
            rst = 1'b0;
        end
        @(negedge refclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
